rx_iq_hold: RTL and testbench
=============================

# rx_iq_hold

Per-channel I/Q holding stage that sits between one DDC channel output and the shared rx audio sample memory. It captures each 24-bit I/Q sample from the DDC into a pending register. On the common audio-rate tick it promotes that sample to a held register. It then serves the held sample as three 16-bit words (I-hi, Q-hi, IQ-lo) under the memory's `rd_i`/`rd_q` strobes. It also counts overrun and underrun events for diagnostics.

## Interface
- `TEST_SEED`, default 16'h0000: initial value of the test-pattern counter.
- `adc_clk` in 1: sole clock.
- Reset is synchronous, active-high.
- `reset_A` in 1: synchronous active-high reset.
- `ddc_i` in 24: DDC I sample, two's complement.
- `ddc_q` in 24: DDC Q sample, two's complement.
- `ddc_avail` in 1: one-cycle strobe; `ddc_i`/`ddc_q` are valid in that cycle.
- `rx_avail_A` in 1: one-cycle common audio tick; promote pending to held.
- `rd_i` in 1: read strobe for the I-hi word (from the memory sequencer).
- `rd_q` in 1: read strobe for the Q-hi word.
- `test_en` in 1: substitute the test pattern for DDC data on capture.
- `dout_A` out 16: registered word output; feeds this channel's 16-bit slice of the memory's channel mux.
- `busy` out 1: high while a readout sequence is in progress.
- `ovr_cnt` out 8: saturating overrun count.
- `udr_cnt` out 8: saturating underrun count.

## Operation
- Capture:
  - When `ddc_avail` = 1: `pend_i <= ddc_i`, `pend_q <= ddc_q`, `pend_v <= 1`.
  - If `pend_v` was already 1 and not cleared by promotion in the same cycle, `ovr_cnt` increments, saturating at 8'hFF. The newer sample overwrites the older one.
- Test mode (`test_en` = 1):
  - On capture, the I value is {8'hA5, tcnt} and the Q value is bitwise ~I.
  - `tcnt` is 16 bits and increments after each capture, wrapping FFFF→0000.
  - `tcnt` holds its value while `test_en` = 0.
- Promotion on `rx_avail_A`, or on a deferred promotion:
  - If the sequencer is IDLE: `held <= pend`, `pend_v <= 0`.
  - If the sequencer is not IDLE, set `defer` = 1. Promotion then occurs in the first cycle the sequencer is IDLE, and `defer` clears.
  - If `pend_v` = 0 at the moment of promotion: `held` is unchanged (the last sample is repeated) and `udr_cnt` increments, saturating.
  - Same-cycle `ddc_avail` and promotion: promotion takes the old pending value. The new sample loads pending with `pend_v` = 1. No overrun is counted.
- Readout sequencer. States: IDLE, SI, SQ, S3.
  - IDLE → SI on `rd_i`; `dout_A <= held_i[23:8]`.
  - SI → SQ on `rd_q`; `dout_A <= held_q[23:8]`.
  - SI with no `rd_q` → IDLE; `dout_A` holds.
  - SQ → S3 unconditionally; `dout_A <= {held_i[7:0], held_q[7:0]}`.
  - S3 → SI if `rd_i` (back-to-back readout); otherwise → IDLE.
  - `rd_q` in any state other than SI is ignored.
  - `rd_i` and `rd_q` asserted together: `rd_i` wins.
  - `busy` = (state != IDLE).
- Reset: all of the following clear on `reset_A`, and reset overrides all other events in the same cycle:
  - `pend`, `held`, `pend_v`, `defer` = 0.
  - state = IDLE.
  - `dout_A` = 0, `busy` = 0.
  - `ovr_cnt` = 0, `udr_cnt` = 0.
  - `tcnt` = `TEST_SEED`.

## Timing
- `dout_A` is registered:
  - `rd_i` sampled at edge t gives the I-hi word valid from t+1.
  - `rd_q` at t+1 gives Q-hi from t+2.
  - IQ-lo is valid from t+3.
  - This one-cycle lag matches the memory's one-cycle-delayed channel mux select.
- Capture to pending: 1 cycle.
- Promotion to held:
  - 1 cycle after `rx_avail_A` when IDLE.
  - Otherwise 1 cycle after the sequencer returns to IDLE.
- `held` never changes between entering SI and leaving S3, so all three words come from the same sample.
- Counters update 1 cycle after the triggering event.

## Structure
- Shared package or header constants:
  - `RX_IQ_W` = 24 and `RX_WORD_W` = 16.
  - Sequencer state encoding (2 bits: IDLE = 0, SI = 1, SQ = 2, S3 = 3).
  - `TEST_TAG` = 8'hA5.
- One natural sub-module, `sat_cnt8`, is a saturating 8-bit counter with synchronous clear; it is instantiated twice (overrun, underrun).
- The top level instantiates one `rx_iq_hold` per rx channel and concatenates the `dout_A` outputs into the memory's channel bus.

## Test plan
- Reset, then capture I = 24'h123456, Q = 24'hABCDEF, then `rx_avail_A`, then `rd_i`, `rd_q` on consecutive cycles → `dout_A` = 16'h1234, 16'hABCD, 16'h56EF on the three following cycles; `busy` is 1 for 3 cycles.
- Two `ddc_avail` strobes before one `rx_avail_A` → `ovr_cnt` = 1; the held sample is the second one.
- Two `rx_avail_A` strobes with one capture between them → `udr_cnt` = 1; the second readout repeats the same three words.
- `rx_avail_A` asserted while in SQ, with a new sample pending → the in-flight S3 word still comes from the old sample; the next readout returns the new sample.
- `test_en` = 1 with `TEST_SEED` = 16'hFFFF and 2 captures → held I = 24'hA5FFFF, then 24'hA50000 (wrap); held Q = 24'h5A0000, then 24'h5AFFFF.
- `reset_A` asserted mid-readout (state SQ) with both counters at 3 → next cycle: `dout_A` = 0, `busy` = 0, both counters = 0, state IDLE; a `rd_q` in the following cycle has no effect.

Source files
------------

// File: rtl/rx_iq_hold_pkg.sv
// rtl/rx_iq_hold_pkg.sv - shared widths, tag and sequencer encoding for rx_iq_hold
package rx_iq_hold_pkg;

    localparam int RX_IQ_W = 24;
    localparam int RX_WORD_W = 16;
    localparam logic [7:0] TEST_TAG = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SI   = 2'd1,
        ST_SQ   = 2'd2,
        ST_S3   = 2'd3
    } seq_state_t;

    function automatic logic [RX_WORD_W-1:0] lo_word(
        input logic [RX_IQ_W-1:0] i_val,
        input logic [RX_IQ_W-1:0] q_val
    );
        return {i_val[7:0], q_val[7:0]};
    endfunction

endpackage

// File: rtl/rx_iq_hold_sat_cnt8.sv
// rtl/rx_iq_hold_sat_cnt8.sv - 8-bit saturating event counter with synchronous clear
module sat_cnt8 (
    input  logic       clk,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= 8'h00;
        end else if (inc && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/rx_iq_hold.sv
// rtl/rx_iq_hold.sv - per-channel I/Q pending/held stage with three-word readout sequencer
module rx_iq_hold
    import rx_iq_hold_pkg::*;
#(
    parameter logic [15:0] TEST_SEED = 16'h0000
) (
    input  logic                 adc_clk,
    input  logic                 reset_A,
    input  logic [RX_IQ_W-1:0]   ddc_i,
    input  logic [RX_IQ_W-1:0]   ddc_q,
    input  logic                 ddc_avail,
    input  logic                 rx_avail_A,
    input  logic                 rd_i,
    input  logic                 rd_q,
    input  logic                 test_en,
    output logic [RX_WORD_W-1:0] dout_A,
    output logic                 busy,
    output logic [7:0]           ovr_cnt,
    output logic [7:0]           udr_cnt
);

    logic [RX_IQ_W-1:0] pend_i, pend_q;
    logic [RX_IQ_W-1:0] held_i, held_q;
    logic [RX_IQ_W-1:0] cap_i, cap_q;
    logic               pend_v;
    logic               defer;
    logic [15:0]        tcnt;
    seq_state_t         state;

    logic promote_req;
    logic seq_free;
    logic do_promote;
    logic ovr_inc;
    logic udr_inc;

    always_comb begin
        cap_i = ddc_i;
        cap_q = ddc_q;
        if (test_en) begin
            cap_i = {TEST_TAG, tcnt};
            cap_q = ~{TEST_TAG, tcnt};
        end
    end

    // An rd_i arriving in IDLE starts a readout this edge, so promotion waits;
    // otherwise the I-hi word and the later words would come from different samples.
    assign promote_req = rx_avail_A | defer;
    assign seq_free    = (state == ST_IDLE) && !rd_i;
    assign do_promote  = promote_req && seq_free;
    assign ovr_inc     = ddc_avail && pend_v && !do_promote;
    assign udr_inc     = do_promote && !pend_v;

    always_ff @(posedge adc_clk) begin
        if (reset_A) begin
            pend_i <= '0;
            pend_q <= '0;
            held_i <= '0;
            held_q <= '0;
            pend_v <= 1'b0;
            defer  <= 1'b0;
            tcnt   <= TEST_SEED;
        end else begin
            if (ddc_avail) begin
                pend_i <= cap_i;
                pend_q <= cap_q;
                if (test_en) begin
                    tcnt <= tcnt + 16'd1;
                end
            end
            if (do_promote && pend_v) begin
                held_i <= pend_i;
                held_q <= pend_q;
            end
            if (ddc_avail) begin
                pend_v <= 1'b1;
            end else if (do_promote) begin
                pend_v <= 1'b0;
            end
            if (do_promote) begin
                defer <= 1'b0;
            end else if (promote_req) begin
                defer <= 1'b1;
            end
        end
    end

    always_ff @(posedge adc_clk) begin
        if (reset_A) begin
            state  <= ST_IDLE;
            dout_A <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_i) begin
                        state  <= ST_SI;
                        dout_A <= held_i[23:8];
                    end
                end
                ST_SI: begin
                    if (rd_i) begin
                        state  <= ST_SI;
                        dout_A <= held_i[23:8];
                    end else if (rd_q) begin
                        state  <= ST_SQ;
                        dout_A <= held_q[23:8];
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SQ: begin
                    state  <= ST_S3;
                    dout_A <= lo_word(held_i, held_q);
                end
                ST_S3: begin
                    if (rd_i) begin
                        state  <= ST_SI;
                        dout_A <= held_i[23:8];
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    sat_cnt8 u_ovr_cnt (
        .clk (adc_clk),
        .clr (reset_A),
        .inc (ovr_inc),
        .cnt (ovr_cnt)
    );

    sat_cnt8 u_udr_cnt (
        .clk (adc_clk),
        .clr (reset_A),
        .inc (udr_inc),
        .cnt (udr_cnt)
    );

endmodule

// File: tb/tb_rx_iq_hold.sv
// tb/tb_rx_iq_hold.sv - scoreboard bench for rx_iq_hold readout, counters and test pattern
module tb_rx_iq_hold;

    logic        adc_clk = 1'b0;
    logic        reset_A = 1'b0;
    logic [23:0] ddc_i = '0;
    logic [23:0] ddc_q = '0;
    logic        ddc_avail = 1'b0;
    logic        rx_avail_A = 1'b0;
    logic        rd_i = 1'b0;
    logic        rd_q = 1'b0;
    logic        test_en = 1'b0;
    logic [15:0] dout_A;
    logic        busy;
    logic [7:0]  ovr_cnt;
    logic [7:0]  udr_cnt;

    int          errors = 0;
    int          checks = 0;
    int          busy_cycles = 0;
    bit          started = 1'b0;
    logic [15:0] exp_q[$];

    rx_iq_hold #(.TEST_SEED(16'hFFFF)) dut (
        .adc_clk    (adc_clk),
        .reset_A    (reset_A),
        .ddc_i      (ddc_i),
        .ddc_q      (ddc_q),
        .ddc_avail  (ddc_avail),
        .rx_avail_A (rx_avail_A),
        .rd_i       (rd_i),
        .rd_q       (rd_q),
        .test_en    (test_en),
        .dout_A     (dout_A),
        .busy       (busy),
        .ovr_cnt    (ovr_cnt),
        .udr_cnt    (udr_cnt)
    );

    always #5 adc_clk = ~adc_clk;

    // every busy cycle presents exactly one new word
    always @(negedge adc_clk) begin
        if (started && busy) begin
            logic [15:0] w;
            busy_cycles++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL dout_unexpected: got %h with no word expected", dout_A);
            end else begin
                w = exp_q.pop_front();
                if (dout_A !== w) begin
                    errors++;
                    $display("FAIL dout_word: got %h expected %h", dout_A, w);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_words(input logic [23:0] iv, input logic [23:0] qv);
        exp_q.push_back(iv[23:8]);
        exp_q.push_back(qv[23:8]);
        exp_q.push_back({iv[7:0], qv[7:0]});
    endtask

    task automatic cap(input logic [23:0] iv, input logic [23:0] qv);
        ddc_i = iv;
        ddc_q = qv;
        ddc_avail = 1'b1;
        cyc();
        ddc_avail = 1'b0;
    endtask

    task automatic tick_rx();
        rx_avail_A = 1'b1;
        cyc();
        rx_avail_A = 1'b0;
    endtask

    task automatic readout(input logic [23:0] iv, input logic [23:0] qv);
        push_words(iv, qv);
        rd_i = 1'b1;
        cyc();
        rd_i = 1'b0;
        rd_q = 1'b1;
        cyc();
        rd_q = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        int bc0;

        reset_A = 1'b1;
        cyc();
        cyc();
        reset_A = 1'b0;
        started = 1'b1;
        chk("reset_dout", {16'h0, dout_A}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_ovr", {24'h0, ovr_cnt}, 32'h0);
        chk("reset_udr", {24'h0, udr_cnt}, 32'h0);

        // basic capture, promote, three-word readout
        cap(24'h123456, 24'hABCDEF);
        tick_rx();
        bc0 = busy_cycles;
        readout(24'h123456, 24'hABCDEF);
        chk("busy_len", busy_cycles - bc0, 32'd3);

        // overrun: second sample wins
        cap(24'h111111, 24'h222222);
        cap(24'h333333, 24'h444444);
        chk("ovr_one", {24'h0, ovr_cnt}, 32'd1);
        tick_rx();
        readout(24'h333333, 24'h444444);

        // underrun: repeat last sample
        cap(24'h555555, 24'h666666);
        tick_rx();
        tick_rx();
        chk("udr_one", {24'h0, udr_cnt}, 32'd1);
        readout(24'h555555, 24'h666666);
        readout(24'h555555, 24'h666666);

        // promotion during SQ is deferred until IDLE
        cap(24'h777777, 24'h888888);
        push_words(24'h555555, 24'h666666);
        rd_i = 1'b1;
        cyc();
        rd_i = 1'b0;
        rd_q = 1'b1;
        cyc();
        rd_q = 1'b0;
        rx_avail_A = 1'b1;
        cyc();
        rx_avail_A = 1'b0;
        cyc();
        cyc();
        readout(24'h777777, 24'h888888);
        chk("udr_after_defer", {24'h0, udr_cnt}, 32'd1);

        // test pattern from seed FFFF with wrap
        test_en = 1'b1;
        cap(24'h000000, 24'h000000);
        tick_rx();
        readout(24'hA5FFFF, 24'h5A0000);
        cap(24'h000000, 24'h000000);
        tick_rx();
        readout(24'hA50000, 24'h5AFFFF);
        test_en = 1'b0;

        // drive both counters to 3, then reset mid-readout
        tick_rx();
        tick_rx();
        cap(24'h010101, 24'h020202);
        cap(24'h030303, 24'h040404);
        cap(24'h050505, 24'h060606);
        chk("ovr_three", {24'h0, ovr_cnt}, 32'd3);
        chk("udr_three", {24'h0, udr_cnt}, 32'd3);
        exp_q.push_back(16'hA500);
        exp_q.push_back(16'h5AFF);
        rd_i = 1'b1;
        cyc();
        rd_i = 1'b0;
        rd_q = 1'b1;
        cyc();
        rd_q = 1'b0;
        reset_A = 1'b1;
        cyc();
        reset_A = 1'b0;
        chk("rst_mid_dout", {16'h0, dout_A}, 32'h0);
        chk("rst_mid_busy", {31'h0, busy}, 32'h0);
        chk("rst_mid_ovr", {24'h0, ovr_cnt}, 32'h0);
        chk("rst_mid_udr", {24'h0, udr_cnt}, 32'h0);
        rd_q = 1'b1;
        cyc();
        rd_q = 1'b0;
        chk("rdq_ignored_busy", {31'h0, busy}, 32'h0);
        chk("rdq_ignored_dout", {16'h0, dout_A}, 32'h0);
        readout(24'h000000, 24'h000000);

        cyc();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
